// File: rtl/de_coder_cmd_sequencer.sv
// Command-write sequencer: buffers parser command words in a small FIFO and
// issues them to the decoder command store via a write/ready handshake with a
// programmable idle gap after every accepted write. Terminates after com_end
// once every buffered word has been written.
module de_coder_cmd_sequencer #(
  parameter int unsigned CMD_W = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_com,
  input  logic [CMD_W-1:0] com_data,
  input  logic             com_end,
  input  logic             wr_ready,
  output logic             write,
  output logic [CMD_W-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] com_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned GAP_W = 8;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nxt;
  logic             end_pend;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  // FIFO status and handshake qualifiers
  assign full  = (count == OCC_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = write && wr_ready;
  assign push  = new_com && (state != S_STOP) && (!full || pop);
  assign drop  = new_com && (state != S_STOP) && full && !pop;

  // Outputs decoded from registered state and FIFO occupancy
  assign write   = (state == S_WRITE);
  assign done    = (state == S_STOP);
  assign busy    = !empty || (state == S_WRITE) || (state == S_GAP);
  assign wr_data = mem[rd_ptr];

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= com_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky status flags and accepted-write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_pend  <= 1'b0;
      overflow  <= 1'b0;
      com_count <= '0;
    end else begin
      if (com_end && (state != S_STOP)) begin
        end_pend <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        com_count <= com_count + CNT_W'(1);
      end
    end
  end

  // State and gap-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RESET;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Next-state logic; buffered data always takes priority over termination
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      S_RESET: state_nxt = S_WAIT;
      S_WAIT: begin
        if (!empty) begin
          state_nxt = S_WRITE;
        end else if (end_pend) begin
          state_nxt = S_STOP;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (GAP != 0) begin
            state_nxt = S_GAP;
            gap_nxt   = GAP_W'(GAP - 1);
          end else if (count > OCC_W'(1)) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = S_WAIT;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      S_STOP:  state_nxt = S_STOP;
      default: state_nxt = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_de_coder_cmd_sequencer.sv
// Directed bench for de_coder_cmd_sequencer: one GAP=1 instance for the main
// scenarios, plus GAP=0 and GAP=3 instances for write-spacing checks.
module tb_de_coder_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;

  logic        new_com, com_end, wr_ready;
  logic [15:0] com_data;
  logic        write, busy, done, overflow;
  logic [15:0] wr_data;
  logic [7:0]  com_count;

  logic        new_com_b, com_end_b, wr_ready_b;
  logic [15:0] com_data_b;
  logic        write0, busy0, done0, ovf0;
  logic [15:0] wr_data0;
  logic [7:0]  cnt0;
  logic        write3, busy3, done3, ovf3;
  logic [15:0] wr_data3;
  logic [7:0]  cnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  de_coder_cmd_sequencer #(.CMD_W(16), .DEPTH(4), .GAP(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .new_com(new_com), .com_data(com_data),
    .com_end(com_end), .wr_ready(wr_ready), .write(write), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow), .com_count(com_count)
  );

  de_coder_cmd_sequencer #(.CMD_W(16), .DEPTH(4), .GAP(0), .CNT_W(8)) dut_g0 (
    .clk(clk), .reset(reset), .new_com(new_com_b), .com_data(com_data_b),
    .com_end(com_end_b), .wr_ready(wr_ready_b), .write(write0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .overflow(ovf0), .com_count(cnt0)
  );

  de_coder_cmd_sequencer #(.CMD_W(16), .DEPTH(4), .GAP(3), .CNT_W(8)) dut_g3 (
    .clk(clk), .reset(reset), .new_com(new_com_b), .com_data(com_data_b),
    .com_end(com_end_b), .wr_ready(wr_ready_b), .write(write3), .wr_data(wr_data3),
    .busy(busy3), .done(done3), .overflow(ovf3), .com_count(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] d_q[$];
    int          c_q[$];
    logic [15:0] d3_q[$];
    int          c3_q[$];
    logic [15:0] sb[$];
    logic [15:0] prev_data;
    logic        prev_stall;
    int          received;
    int          sent;
    int          done_at;
    logic [15:0] t5_words[3];

    reset = 1'b1;
    new_com = 1'b0; com_end = 1'b0; wr_ready = 1'b0; com_data = '0;
    new_com_b = 1'b0; com_end_b = 1'b0; wr_ready_b = 1'b0; com_data_b = '0;
    repeat (3) tick();

    chk("rst_write",    32'(write),     32'h0);
    chk("rst_busy",     32'(busy),      32'h0);
    chk("rst_done",     32'(done),      32'h0);
    chk("rst_overflow", 32'(overflow),  32'h0);
    chk("rst_count",    32'(com_count), 32'h0);

    reset = 1'b0;
    tick();

    // single word: write appears two cycles after new_com
    new_com = 1'b1; com_data = 16'hA5A5; wr_ready = 1'b1;
    tick();
    new_com = 1'b0;
    chk("t1_write_n1", 32'(write), 32'h0);
    tick();
    chk("t1_write_n2", 32'(write),   32'h1);
    chk("t1_wr_data",  32'(wr_data), 32'hA5A5);
    tick();
    chk("t1_count", 32'(com_count), 32'h1);
    chk("t1_gap",   32'(write),     32'h0);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // GAP=0 back-to-back and GAP=3 spacing with three queued words
    t5_words[0] = 16'h0011; t5_words[1] = 16'h0022; t5_words[2] = 16'h0033;
    wr_ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      new_com_b = 1'b1; com_data_b = t5_words[i];
      tick();
    end
    new_com_b = 1'b0;
    wr_ready_b = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (write0) begin d_q.push_back(wr_data0); c_q.push_back(cyc); end
      if (write3) begin d3_q.push_back(wr_data3); c3_q.push_back(cyc); end
      tick();
    end
    chk("t5_g0_n", 32'(d_q.size()), 32'd3);
    chk("t5_g3_n", 32'(d3_q.size()), 32'd3);
    if (d_q.size() == 3 && d3_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t5_g0_data", 32'(d_q[i]),  32'(t5_words[i]));
        chk("t5_g3_data", 32'(d3_q[i]), 32'(t5_words[i]));
      end
      for (int i = 1; i < 3; i++) begin
        chk("t5_g0_space", 32'(c_q[i] - c_q[i-1]),   32'd1);
        chk("t5_g3_space", 32'(c3_q[i] - c3_q[i-1]), 32'd5);
      end
    end
    chk("t5_g0_count", 32'(cnt0), 32'd3);
    chk("t5_g3_count", 32'(cnt3), 32'd3);
    d_q.delete(); c_q.delete();

    // fill while stalled, overflow on the fifth word, then drain in order
    wr_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      new_com = 1'b1; com_data = 16'(i);
      tick();
      if (i == 4) chk("t2_no_ovf_yet", 32'(overflow), 32'h0);
    end
    new_com = 1'b0;
    chk("t2_overflow", 32'(overflow), 32'h1);
    repeat (5) tick();
    chk("t2_stall_write", 32'(write),   32'h1);
    chk("t2_stall_data",  32'(wr_data), 32'h1);
    wr_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (write && wr_ready) begin d_q.push_back(wr_data); c_q.push_back(cyc); end
      tick();
    end
    chk("t2_nwrites", 32'(d_q.size()), 32'd4);
    if (d_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", 32'(d_q[i]), 32'(i + 1));
      for (int i = 1; i < 4; i++) chk("t2_space", 32'(c_q[i] - c_q[i-1]), 32'd3);
    end
    chk("t2_count",  32'(com_count), 32'd5);
    chk("t2_sticky", 32'(overflow),  32'h1);
    d_q.delete(); c_q.delete();

    // random back-pressure over 100 words
    received = 0; sent = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 2000 && received < 100; cyc++) begin
      wr_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        chk("t3_hold_write", 32'(write),   32'h1);
        chk("t3_hold_data",  32'(wr_data), 32'(prev_data));
      end
      if (write && wr_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $error("FAIL t3_spurious: observed write of %0h expected none", wr_data);
        end else begin
          chk("t3_data", 32'(wr_data), 32'(sb.pop_front()));
          received++;
        end
      end
      new_com = 1'b0;
      if (sent < 100 && sb.size() < 4 && $urandom_range(0, 1) == 1) begin
        new_com = 1'b1;
        com_data = 16'($urandom);
        sb.push_back(com_data);
        sent++;
      end
      prev_stall = write && !wr_ready;
      prev_data  = wr_data;
      tick();
    end
    new_com = 1'b0;
    chk("t3_received", 32'(received),  32'd100);
    chk("t3_leftover", 32'(sb.size()), 32'd0);
    chk("t3_count",    32'(com_count), 32'd105);
    wr_ready = 1'b1;
    repeat (6) tick();
    chk("t3_idle", 32'(busy), 32'h0);

    // asynchronous reset in the middle of a stalled write
    wr_ready = 1'b0;
    new_com = 1'b1; com_data = 16'h1234;
    tick();
    new_com = 1'b0;
    tick();
    chk("t6_prewrite", 32'(write), 32'h1);
    #3 reset = 1'b1;
    #1;
    chk("t6_write",    32'(write),     32'h0);
    chk("t6_busy",     32'(busy),      32'h0);
    chk("t6_count",    32'(com_count), 32'h0);
    chk("t6_overflow", 32'(overflow),  32'h0);
    tick();
    reset = 1'b0;
    tick();
    wr_ready = 1'b1;
    new_com = 1'b1; com_data = 16'hBEEF;
    tick();
    new_com = 1'b0;
    tick();
    chk("t6_rs_write", 32'(write),   32'h1);
    chk("t6_rs_data",  32'(wr_data), 32'hBEEF);
    tick();
    chk("t6_rs_count", 32'(com_count), 32'h1);
    repeat (2) tick();

    // com_end together with a word while two are buffered, then terminate
    wr_ready = 1'b0;
    new_com = 1'b1; com_data = 16'h0008;
    tick();
    com_data = 16'h0009;
    tick();
    com_data = 16'h0007; com_end = 1'b1;
    tick();
    new_com = 1'b0; com_end = 1'b0;
    chk("t4_not_done", 32'(done), 32'h0);
    wr_ready = 1'b1;
    done_at = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) begin done_at = cyc; break; end
      if (write && wr_ready) begin d_q.push_back(wr_data); c_q.push_back(cyc); end
      tick();
    end
    chk("t4_nwrites", 32'(d_q.size()), 32'd3);
    if (d_q.size() == 3) begin
      chk("t4_w0", 32'(d_q[0]), 32'h8);
      chk("t4_w1", 32'(d_q[1]), 32'h9);
      chk("t4_w2", 32'(d_q[2]), 32'h7);
      chk("t4_done_at", 32'(done_at), 32'(c_q[2] + 3));
    end
    chk("t4_done",  32'(done),      32'h1);
    chk("t4_count", 32'(com_count), 32'd4);
    for (int i = 0; i < 6; i++) begin
      new_com = 1'b1; com_data = 16'hDEAD;
      tick();
    end
    new_com = 1'b0;
    chk("t4_stop_ovf",   32'(overflow),  32'h0);
    chk("t4_stop_done",  32'(done),      32'h1);
    chk("t4_stop_write", 32'(write),     32'h0);
    chk("t4_stop_busy",  32'(busy),      32'h0);
    chk("t4_stop_count", 32'(com_count), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
